// File: rtl/invader_fleet_controller.sv
// Invader formation sequencer: paces fleet steps from frame pulses, bounces the
// fleet between screen edges, tracks hits and raises cleared/landed flags.
module invader_fleet_controller #(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 8,
  parameter int unsigned START_X     = 64,
  parameter int unsigned START_Y     = 48,
  parameter int unsigned SPACING_X   = 40,
  parameter int unsigned SPACING_Y   = 32,
  parameter int unsigned INV_WIDTH   = 24,
  parameter int unsigned INV_HEIGHT  = 16,
  parameter int unsigned STEP_X      = 8,
  parameter int unsigned DROP_Y      = 16,
  parameter int unsigned LEFT_BOUND  = 8,
  parameter int unsigned RIGHT_BOUND = 632,
  parameter int unsigned FLOOR_Y     = 416,
  parameter int unsigned MIN_PERIOD  = 2,
  parameter int unsigned SPEED_SHIFT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame,
  input  logic                   enable,
  input  logic                   hit_valid,
  input  logic [5:0]             hit_index,
  output logic [9:0]             fleet_x,
  output logic [9:0]             fleet_y,
  output logic [ROWS*COLS-1:0]   alive_mask,
  output logic [6:0]             alive_count,
  output logic                   dir_right,
  output logic                   step_strobe,
  output logic                   busy,
  output logic                   cleared,
  output logic                   landed
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned POS_W = 11;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {S_WAIT, S_SCAN, S_MOVE, S_HALT} state_e;

  state_e             state_q, state_d;
  logic [9:0]         fleet_x_q, fleet_x_d, fleet_y_q, fleet_y_d;
  logic [N-1:0]       alive_mask_q, alive_mask_d, snap_q, snap_d;
  logic [6:0]         alive_count_q, alive_count_d;
  logic               dir_right_q, dir_right_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [COL_W-1:0]   scan_col_q, scan_col_d;
  logic [5:0]         left_q, left_d, right_q, right_d;
  logic               found_q, found_d;
  logic               step_strobe_q, step_strobe_d;
  logic               busy_q, busy_d;
  logic               cleared_q, cleared_d;
  logic               landed_q, landed_d;

  logic [COLS-1:0]    col_occ;
  logic [5:0]         bottom_row;
  logic [N-1:0]       hit_oh;
  logic               hit_ok;
  logic               frame_go;
  logic [CNT_W-1:0]   cnt_inc, period;
  logic [POS_W-1:0]   right_ext, left_ext, drop_y, land_ext;
  logic               at_edge;

  // Column occupancy and lowest occupied row of the snapshot
  always_comb begin
    col_occ    = '0;
    bottom_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_occ[c] = col_occ[c] | snap_q[r*COLS + c];
      end
      if (|snap_q[r*COLS +: COLS]) bottom_row = 6'(r);
    end
  end

  // Hit qualification, step pacing and edge arithmetic
  always_comb begin
    hit_oh    = N'(1) << hit_index;
    hit_ok    = hit_valid && (7'(hit_index) < 7'(N)) && (|(alive_mask_q & hit_oh));
    frame_go  = frame && enable;
    cnt_inc   = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + CNT_W'(1);
    period    = CNT_W'(MIN_PERIOD) + CNT_W'(alive_count_q >> SPEED_SHIFT);
    right_ext = POS_W'(fleet_x_q) + POS_W'(right_q) * POS_W'(SPACING_X)
              + POS_W'(INV_WIDTH + STEP_X);
    left_ext  = POS_W'(fleet_x_q) + POS_W'(left_q) * POS_W'(SPACING_X);
    drop_y    = POS_W'(fleet_y_q) + POS_W'(DROP_Y);
    land_ext  = drop_y + POS_W'(bottom_row) * POS_W'(SPACING_Y) + POS_W'(INV_HEIGHT);
    at_edge   = dir_right_q ? (right_ext > POS_W'(RIGHT_BOUND))
                            : (left_ext < POS_W'(LEFT_BOUND + STEP_X));
  end

  always_comb begin
    state_d       = state_q;
    fleet_x_d     = fleet_x_q;
    fleet_y_d     = fleet_y_q;
    alive_mask_d  = alive_mask_q;
    alive_count_d = alive_count_q;
    dir_right_d   = dir_right_q;
    frame_cnt_d   = frame_cnt_q;
    snap_d        = snap_q;
    scan_col_d    = scan_col_q;
    left_d        = left_q;
    right_d       = right_q;
    found_d       = found_q;
    step_strobe_d = 1'b0;
    landed_d      = landed_q;

    if (hit_ok) begin
      alive_mask_d  = alive_mask_q & ~hit_oh;
      alive_count_d = alive_count_q - 7'd1;
    end

    case (state_q)
      S_WAIT: begin
        if (alive_count_d == '0) begin
          state_d = S_HALT;
        end else if (frame_go) begin
          // >= so a period that shrank below the count fires on this frame
          if (cnt_inc >= period) begin
            frame_cnt_d = '0;
            snap_d      = alive_mask_q;
            scan_col_d  = '0;
            found_d     = 1'b0;
            left_d      = '0;
            right_d     = '0;
            state_d     = S_SCAN;
          end else begin
            frame_cnt_d = cnt_inc;
          end
        end
      end
      S_SCAN: begin
        if (frame_go) frame_cnt_d = cnt_inc;
        if (col_occ[scan_col_q]) begin
          if (!found_q) left_d = 6'(scan_col_q);
          right_d = 6'(scan_col_q);
          found_d = 1'b1;
        end
        if (scan_col_q == COL_W'(COLS - 1)) state_d = S_MOVE;
        else scan_col_d = scan_col_q + COL_W'(1);
      end
      S_MOVE: begin
        if (frame_go) frame_cnt_d = cnt_inc;
        step_strobe_d = 1'b1;
        if (at_edge) begin
          fleet_y_d   = drop_y[9:0];
          dir_right_d = !dir_right_q;
        end else if (dir_right_q) begin
          fleet_x_d = fleet_x_q + 10'(STEP_X);
        end else begin
          fleet_x_d = fleet_x_q - 10'(STEP_X);
        end
        if (at_edge && (land_ext >= POS_W'(FLOOR_Y))) begin
          landed_d = 1'b1;
          state_d  = S_HALT;
        end else if (alive_count_d == '0) begin
          state_d = S_HALT;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = state_q;
    endcase

    cleared_d = cleared_q | (alive_count_d == '0);
    busy_d    = (state_d == S_SCAN) || (state_d == S_MOVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_WAIT;
      fleet_x_q     <= 10'(START_X);
      fleet_y_q     <= 10'(START_Y);
      alive_mask_q  <= '1;
      alive_count_q <= 7'(N);
      dir_right_q   <= 1'b1;
      frame_cnt_q   <= '0;
      snap_q        <= '0;
      scan_col_q    <= '0;
      left_q        <= '0;
      right_q       <= '0;
      found_q       <= 1'b0;
      step_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
      cleared_q     <= 1'b0;
      landed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fleet_x_q     <= fleet_x_d;
      fleet_y_q     <= fleet_y_d;
      alive_mask_q  <= alive_mask_d;
      alive_count_q <= alive_count_d;
      dir_right_q   <= dir_right_d;
      frame_cnt_q   <= frame_cnt_d;
      snap_q        <= snap_d;
      scan_col_q    <= scan_col_d;
      left_q        <= left_d;
      right_q       <= right_d;
      found_q       <= found_d;
      step_strobe_q <= step_strobe_d;
      busy_q        <= busy_d;
      cleared_q     <= cleared_d;
      landed_q      <= landed_d;
    end
  end

  assign fleet_x     = fleet_x_q;
  assign fleet_y     = fleet_y_q;
  assign alive_mask  = alive_mask_q;
  assign alive_count = alive_count_q;
  assign dir_right   = dir_right_q;
  assign step_strobe = step_strobe_q;
  assign busy        = busy_q;
  assign cleared     = cleared_q;
  assign landed      = landed_q;

endmodule

// File: tb/tb_invader_fleet_controller.sv
// Directed bench for invader_fleet_controller: pacing, edge bounce, hits,
// landing, mid-scan reset and fleet clear, with hand-computed expectations.
module tb_invader_fleet_controller;

  logic        clk = 1'b0;
  logic        rst, frame, enable, hit_valid;
  logic [5:0]  hit_index;
  logic [9:0]  fleet_x, fleet_y;
  logic [31:0] alive_mask;
  logic [6:0]  alive_count;
  logic        dir_right, step_strobe, busy, cleared, landed;

  int n_checks = 0;
  int n_pass   = 0;

  invader_fleet_controller dut (
    .clk(clk), .rst(rst), .frame(frame), .enable(enable),
    .hit_valid(hit_valid), .hit_index(hit_index),
    .fleet_x(fleet_x), .fleet_y(fleet_y), .alive_mask(alive_mask),
    .alive_count(alive_count), .dir_right(dir_right), .step_strobe(step_strobe),
    .busy(busy), .cleared(cleared), .landed(landed)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic hit(input int idx);
    @(negedge clk);
    hit_valid = 1'b1;
    hit_index = 6'(idx);
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
  endtask

  // Issue frames until a step starts, optionally killing a column during SCAN
  task automatic do_step(input int scan_col, output logic ok, output int nframes);
    ok = 1'b0;
    nframes = 0;
    while (!ok && nframes < 200) begin
      pulse_frame();
      nframes++;
      if (busy) begin
        if (scan_col >= 0) begin
          for (int r = 0; r < 4; r++) begin
            hit_valid = 1'b1;
            hit_index = 6'(r * 8 + scan_col);
            @(negedge clk);
          end
          hit_valid = 1'b0;
        end
        for (int c = 0; c < 20 && !step_strobe; c++) @(negedge clk);
        ok = step_strobe;
        if (!ok) break;
      end
    end
  endtask

  task automatic run_steps(input int n, output logic all_ok);
    logic ok;
    int   nf;
    all_ok = 1'b1;
    for (int s = 0; s < n; s++) begin
      do_step(-1, ok, nf);
      if (!ok) begin
        all_ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic watch(input int n, input logic toggle, output int busy_cnt,
                       output int strobe_at, output int strobe_cnt);
    busy_cnt = 0;
    strobe_at = 0;
    strobe_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      frame = toggle && (i % 2 == 0);
      if (busy) busy_cnt++;
      if (step_strobe) begin
        strobe_cnt++;
        if (strobe_at == 0) strobe_at = i;
      end
    end
    frame = 1'b0;
  endtask

  initial begin
    logic       ok;
    int         nf, bc, sa, sc, drops, steps;
    logic [9:0] prev_y;

    rst = 1'b1; frame = 1'b0; enable = 1'b1; hit_valid = 1'b0; hit_index = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_fleet_x", fleet_x, 64);
    check("rst_fleet_y", fleet_y, 48);
    check("rst_mask", alive_mask, 32'hFFFF_FFFF);
    check("rst_count", alive_count, 32);
    check("rst_dir", dir_right, 1);
    check("rst_strobe", step_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_cleared", cleared, 0);
    check("rst_landed", landed, 0);

    // 17 enabled frames with 5 disabled ones interleaved: no step yet
    repeat (10) pulse_frame();
    enable = 1'b0;
    repeat (5) pulse_frame();
    enable = 1'b1;
    repeat (7) pulse_frame();
    check("no_step_before_period", busy, 0);
    check("x_before_period", fleet_x, 64);

    @(negedge clk);
    frame = 1'b1;
    watch(12, 1'b0, bc, sa, sc);
    check("first_step_latency", sa, 10);
    check("first_step_busy_cycles", bc, 9);
    check("first_step_strobe_width", sc, 1);
    check("first_step_x", fleet_x, 72);
    check("first_step_y", fleet_y, 48);

    // Full fleet marches right: steps 2..33, then edge drop on 34
    do_step(-1, ok, nf);
    check("full_period_frames", nf, 18);
    run_steps(31, ok);
    check("march_ok", ok, 1);
    check("step33_x", fleet_x, 328);
    check("step33_y", fleet_y, 48);
    check("step33_dir", dir_right, 1);
    do_step(-1, ok, nf);
    check("step34_x", fleet_x, 328);
    check("step34_y", fleet_y, 64);
    check("step34_dir", dir_right, 0);

    // Kill column 7
    hit(7); hit(15); hit(23); hit(31);
    check("col7_count", alive_count, 28);
    check("col7_mask", alive_mask, 32'h7F7F_7F7F);
    do_step(-1, ok, nf);
    check("period28_frames", nf, 16);
    check("left_first_x", fleet_x, 320);
    run_steps(39, ok);
    check("left_march_ok", ok, 1);
    check("left_end_x", fleet_x, 8);
    check("left_end_dir", dir_right, 0);
    do_step(-1, ok, nf);
    check("left_drop_x", fleet_x, 8);
    check("left_drop_y", fleet_y, 80);
    check("left_drop_dir", dir_right, 1);
    run_steps(45, ok);
    check("right_march_ok", ok, 1);
    check("col6_edge_x", fleet_x, 368);
    check("col6_edge_y", fleet_y, 80);

    // Column 6 dies during SCAN; the step still sees it and drops
    do_step(6, ok, nf);
    check("scan_hit_step_ok", ok, 1);
    check("scan_hit_x", fleet_x, 368);
    check("scan_hit_y", fleet_y, 96);
    check("scan_hit_dir", dir_right, 0);
    check("scan_hit_count", alive_count, 24);
    check("scan_hit_mask", alive_mask, 32'h3F3F_3F3F);

    // Ignored hits: already dead and out of range
    hit(7);
    check("dup7_count", alive_count, 24);
    hit(40);
    check("oor40_count", alive_count, 24);
    check("oor40_mask", alive_mask, 32'h3F3F_3F3F);
    hit(6);
    check("dup6_count", alive_count, 24);

    // Leave invaders 24 and 29 (bottom row) and march to the floor
    for (int i = 0; i < 32; i++) if (i != 24 && i != 29) hit(i);
    check("pair_count", alive_count, 2);
    check("pair_mask", alive_mask, 32'h2100_0000);
    drops = 0;
    steps = 0;
    ok = 1'b1;
    while (!landed && steps < 1500) begin
      prev_y = fleet_y;
      do_step(-1, ok, nf);
      if (!ok) break;
      if (fleet_y != prev_y) drops++;
      steps++;
    end
    check("land_step_ok", ok, 1);
    check("landed", landed, 1);
    check("land_y", fleet_y, 304);
    check("land_x", fleet_x, 8);
    check("land_drops", drops, 13);
    check("land_steps", steps, 658);
    check("land_busy", busy, 0);
    watch(40, 1'b1, bc, sa, sc);
    check("halt_no_strobe", sc, 0);
    check("halt_no_busy", bc, 0);
    check("halt_y_frozen", fleet_y, 304);

    // Hits still land while halted
    hit(29);
    check("halt_hit_count", alive_count, 1);
    check("halt_hit_mask", alive_mask, 32'h0100_0000);
    check("halt_not_cleared", cleared, 0);
    hit(24);
    check("halt_clear_count", alive_count, 0);
    check("halt_cleared", cleared, 1);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rerst_landed", landed, 0);
    check("rerst_cleared", cleared, 0);
    check("rerst_count", alive_count, 32);

    // 31 alive -> period 17; reset asynchronously mid-SCAN
    hit(3);
    check("odd_count", alive_count, 31);
    repeat (16) pulse_frame();
    check("odd_period_not_yet", busy, 0);
    pulse_frame();
    check("odd_period_fires", busy, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_count", alive_count, 32);
    check("async_mask", alive_mask, 32'hFFFF_FFFF);
    check("async_x", fleet_x, 64);
    check("async_dir", dir_right, 1);
    @(negedge clk); rst = 1'b0;
    watch(14, 1'b0, bc, sa, sc);
    check("aborted_scan_no_strobe", sc, 0);
    check("aborted_scan_no_busy", bc, 0);

    // Clear the whole fleet
    for (int i = 0; i < 31; i++) hit(i);
    check("last_one_count", alive_count, 1);
    check("last_one_cleared", cleared, 0);
    hit(31);
    check("all_dead_count", alive_count, 0);
    check("all_dead_mask", alive_mask, 0);
    check("all_dead_cleared", cleared, 1);
    watch(40, 1'b1, bc, sa, sc);
    check("cleared_no_strobe", sc, 0);
    check("cleared_no_busy", bc, 0);
    check("cleared_x_frozen", fleet_x, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/invader_fleet_controller.md
Name: invader_fleet_controller

Overview:
- Sequences the invader formation that the VGA sprite datapath draws.
- Once per N frames it steps the fleet origin horizontally. At a screen edge it drops the fleet one row and reverses direction.
- Maintains the alive mask from collision hits and speeds up as invaders die.
- Flags cleared (all dead) and landed (fleet reached the floor) for the game FSM.
- Outputs fleet_x/fleet_y/alive_mask feed the per-invader draw logic; hit inputs come from the pixel-level collision detector.

Parameters:
- ROWS, 4, formation rows (row 0 = top).
- COLS, 8, formation columns (col 0 = left); ROWS*COLS <= 64.
- START_X, 64, fleet origin x after reset.
- START_Y, 48, fleet origin y after reset.
- SPACING_X, 40, column pitch in pixels.
- SPACING_Y, 32, row pitch in pixels.
- INV_WIDTH, 24, scaled invader width.
- INV_HEIGHT, 16, scaled invader height.
- STEP_X, 8, horizontal step per move.
- DROP_Y, 16, vertical drop at an edge.
- LEFT_BOUND, 8, leftmost legal pixel.
- RIGHT_BOUND, 632, rightmost legal pixel extent.
- FLOOR_Y, 416, landing line.
- MIN_PERIOD, 2, minimum frames between steps.
- SPEED_SHIFT, 1, period = MIN_PERIOD + (alive_count >> SPEED_SHIFT).

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, asynchronous active-high reset.
- frame, input, 1, one-cycle end-of-frame pulse from the VGA timing generator.
- enable, input, 1, game running; when 0, no frame counting and no steps.
- hit_valid, input, 1, one-cycle invader hit strobe.
- hit_index, input, 6, hit invader, index = row*COLS + col.
- fleet_x, output, 10, formation origin x (top-left of invader 0).
- fleet_y, output, 10, formation origin y.
- alive_mask, output, ROWS*COLS, bit i = invader i alive.
- alive_count, output, 7, number of alive invaders.
- dir_right, output, 1, 1 = moving right.
- step_strobe, output, 1, one-cycle pulse on the cycle fleet_x/fleet_y change.
- busy, output, 1, high in SCAN and MOVE.
- cleared, output, 1, sticky: alive_count == 0.
- landed, output, 1, sticky: fleet reached FLOOR_Y.

Behaviour:
Reset values (asynchronous, while rst is high):
- fleet_x=START_X, fleet_y=START_Y.
- alive_mask all ones, alive_count=ROWS*COLS.
- dir_right=1, frame counter=0, state=WAIT.
- step_strobe, busy, cleared, landed all 0.

States: WAIT, SCAN, MOVE, HALT.

WAIT:
- On frame && enable, increment the frame counter.
- When the incremented value would equal the period:
  - clear the counter;
  - snapshot alive_mask;
  - next state = SCAN.
- The period is computed from the current alive_count.

SCAN:
- Exactly COLS cycles, examining one column per cycle (OR over the rows of the snapshot).
- Records leftmost and rightmost occupied columns, and the bottommost occupied row (computed from the snapshot).
- Frame pulses during SCAN/MOVE increment the counter but never start a new step.

MOVE (one cycle; outputs registered, step_strobe high the following cycle):
- All bound arithmetic is 11-bit unsigned; no wrap.
- Right-moving: if fleet_x + rightmost*SPACING_X + INV_WIDTH + STEP_X > RIGHT_BOUND, then fleet_y += DROP_Y and dir_right=0. Otherwise fleet_x += STEP_X.
- Left-moving: if fleet_x + leftmost*SPACING_X < LEFT_BOUND + STEP_X, then drop and set dir_right=1. Otherwise fleet_x -= STEP_X.
- After a drop, if new fleet_y + bottom*SPACING_Y + INV_HEIGHT >= FLOOR_Y, then landed=1 and next state = HALT.
- Otherwise next state = WAIT.
- Latency: frame pulse at cycle t gives SCAN over t+1..t+COLS, MOVE at t+COLS+1, and new position plus step_strobe at t+COLS+2.

Hits:
- Accepted in every state, including HALT.
- A hit with hit_index < ROWS*COLS and the bit set clears the bit and decrements alive_count on the next edge.
- An out-of-range index or an already-dead invader is ignored; count unchanged.
- Hits during SCAN do not alter the snapshot; they take effect on the next step.

Cleared:
- When alive_count becomes 0: cleared=1 and state = HALT.
- A step in flight completes first, then the FSM goes to HALT.

HALT: fleet frozen, busy=0. Only rst exits HALT.

enable low:
- Counter holds.
- An in-flight SCAN/MOVE completes.

Period:
- Evaluated against the counter each frame.
- If the period shrinks below the current counter value, trigger on the next frame pulse.

Test Plan:
- Reset, enable=1, 18 frame pulses -> step_strobe at cycle COLS+2 after 18th pulse; fleet_x=72, fleet_y=48, busy high 9 cycles.
- Full fleet, 34 steps -> 33 steps reach fleet_x=328; 34th step gives fleet_x=328, fleet_y=64, dir_right=0.
- Hit indices 7,15,23,31 -> alive_count=28, rightmost col 6, drop occurs when fleet_x=368 (first x with x+272>632); period becomes 16 frames.
- Duplicate hit index 7 and hit_index 40 -> mask and count unchanged; simultaneous hit during SCAN applied but step uses snapshot.
- Drive fleet down 16 drops (fleet_y=304, bottom row 3) -> landed=1, HALT, no further step_strobe; rst mid-SCAN -> all outputs to reset values immediately.
- Hit all 32 invaders -> alive_count=0, cleared=1, HALT; later frames produce no step_strobe.
